// File: rtl/item_price_table.sv
// Registered item price table with one-cycle lookup, credit comparison and change computation.
// Same-cycle write and lookup of one entry returns the incoming price (write-first).
module item_price_table #(
   parameter int                 NUM_ITEMS     = 8,
   parameter int                 SEL_W         = 3,
   parameter int                 PRICE_W       = 8,
   parameter logic [PRICE_W-1:0] DEFAULT_PRICE = 8'd100
) (
   input  logic               Clock,
   input  logic               Resetn,
   input  logic               wr_en,
   input  logic [SEL_W-1:0]   wr_item,
   input  logic [PRICE_W-1:0] wr_price,
   input  logic               sel_valid,
   input  logic [SEL_W-1:0]   sel,
   input  logic [PRICE_W-1:0] credit,
   output logic [PRICE_W-1:0] price,
   output logic               price_valid,
   output logic               sel_err,
   output logic               enough,
   output logic [PRICE_W-1:0] change,
   output logic               wr_err
);

   logic [PRICE_W-1:0] table_q [NUM_ITEMS];

   logic [PRICE_W-1:0] price_q, price_d;
   logic [PRICE_W-1:0] change_q, change_d;
   logic               price_valid_q, price_valid_d;
   logic               sel_err_q, sel_err_d;
   logic               enough_q, enough_d;
   logic               wr_err_q, wr_err_d;

   logic               wr_ok;
   logic               sel_ok;
   logic [PRICE_W-1:0] lk_price;

   always_comb begin
      wr_ok    = wr_en && (32'(wr_item) < 32'(NUM_ITEMS));
      sel_ok   = 32'(sel) < 32'(NUM_ITEMS);
      lk_price = '0;
      if (sel_ok) begin
         // Bypass so a lookup racing a write to the same entry sees the new price.
         if (wr_ok && (wr_item == sel)) lk_price = wr_price;
         else                           lk_price = table_q[sel];
      end

      price_d       = price_q;
      sel_err_d     = sel_err_q;
      enough_d      = enough_q;
      change_d      = change_q;
      price_valid_d = sel_valid;
      wr_err_d      = wr_en && !wr_ok;
      if (sel_valid) begin
         price_d   = lk_price;
         sel_err_d = !sel_ok;
         enough_d  = sel_ok && (credit >= lk_price);
         change_d  = enough_d ? (credit - lk_price) : '0;
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         for (int i = 0; i < NUM_ITEMS; i++) table_q[i] <= DEFAULT_PRICE;
         price_q       <= '0;
         change_q      <= '0;
         price_valid_q <= 1'b0;
         sel_err_q     <= 1'b0;
         enough_q      <= 1'b0;
         wr_err_q      <= 1'b0;
      end else begin
         if (wr_ok) table_q[wr_item] <= wr_price;
         price_q       <= price_d;
         change_q      <= change_d;
         price_valid_q <= price_valid_d;
         sel_err_q     <= sel_err_d;
         enough_q      <= enough_d;
         wr_err_q      <= wr_err_d;
      end
   end

   assign price       = price_q;
   assign change      = change_q;
   assign price_valid = price_valid_q;
   assign sel_err     = sel_err_q;
   assign enough      = enough_q;
   assign wr_err      = wr_err_q;

endmodule

// File: tb/tb_item_price_table.sv
// Bench for item_price_table: two instances (8 and 6 items) share stimulus and are
// checked every cycle against an array-based price model.
module tb_item_price_table;

   logic       Clock = 1'b0;
   logic       Resetn = 1'b0;
   logic       wr_en = 1'b0;
   logic [2:0] wr_item = '0;
   logic [7:0] wr_price = '0;
   logic       sel_valid = 1'b0;
   logic [2:0] sel = '0;
   logic [7:0] credit = '0;

   logic [7:0] price_a, change_a, price_b, change_b;
   logic       pv_a, se_a, en_a, we_a, pv_b, se_b, en_b, we_b;

   int total = 0;
   int bad = 0;

   int n_items [2] = '{8, 6};
   int tbl [2][16];
   int e_price [2], e_pv [2], e_se [2], e_en [2], e_ch [2], e_we [2];

   always #5 Clock = ~Clock;

   item_price_table #(.NUM_ITEMS(8), .SEL_W(3), .PRICE_W(8), .DEFAULT_PRICE(8'd100)) dut_a (
      .Clock(Clock), .Resetn(Resetn), .wr_en(wr_en), .wr_item(wr_item), .wr_price(wr_price),
      .sel_valid(sel_valid), .sel(sel), .credit(credit), .price(price_a), .price_valid(pv_a),
      .sel_err(se_a), .enough(en_a), .change(change_a), .wr_err(we_a));

   item_price_table #(.NUM_ITEMS(6), .SEL_W(3), .PRICE_W(8), .DEFAULT_PRICE(8'd100)) dut_b (
      .Clock(Clock), .Resetn(Resetn), .wr_en(wr_en), .wr_item(wr_item), .wr_price(wr_price),
      .sel_valid(sel_valid), .sel(sel), .credit(credit), .price(price_b), .price_valid(pv_b),
      .sel_err(se_b), .enough(en_b), .change(change_b), .wr_err(we_b));

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      total++;
      assert (obs === 32'(exp)) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 16; i++) tbl[d][i] = 100;
         e_price[d] = 0; e_pv[d] = 0; e_se[d] = 0; e_en[d] = 0; e_ch[d] = 0; e_we[d] = 0;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, " A.price"},       {24'd0, price_a},  e_price[0]);
      chk({tag, " A.price_valid"}, {31'd0, pv_a},     e_pv[0]);
      chk({tag, " A.sel_err"},     {31'd0, se_a},     e_se[0]);
      chk({tag, " A.enough"},      {31'd0, en_a},     e_en[0]);
      chk({tag, " A.change"},      {24'd0, change_a}, e_ch[0]);
      chk({tag, " A.wr_err"},      {31'd0, we_a},     e_we[0]);
      chk({tag, " B.price"},       {24'd0, price_b},  e_price[1]);
      chk({tag, " B.price_valid"}, {31'd0, pv_b},     e_pv[1]);
      chk({tag, " B.sel_err"},     {31'd0, se_b},     e_se[1]);
      chk({tag, " B.enough"},      {31'd0, en_b},     e_en[1]);
      chk({tag, " B.change"},      {24'd0, change_b}, e_ch[1]);
      chk({tag, " B.wr_err"},      {31'd0, we_b},     e_we[1]);
   endtask

   // Drive one cycle of stimulus, advance the model across the edge, then check.
   task automatic step(input string tag, input bit we, input int wi, input int wp,
                       input bit sv, input int s, input int cr);
      int p;
      wr_en = we; wr_item = 3'(wi); wr_price = 8'(wp);
      sel_valid = sv; sel = 3'(s); credit = 8'(cr);
      @(posedge Clock);
      for (int d = 0; d < 2; d++) begin
         e_we[d] = (we && wi >= n_items[d]) ? 1 : 0;
         e_pv[d] = sv ? 1 : 0;
         if (sv) begin
            if (s >= n_items[d]) begin
               e_price[d] = 0; e_se[d] = 1; e_en[d] = 0; e_ch[d] = 0;
            end else begin
               p = (we && wi == s) ? wp : tbl[d][s];
               e_price[d] = p; e_se[d] = 0;
               e_en[d] = (cr >= p) ? 1 : 0;
               e_ch[d] = (cr >= p) ? cr - p : 0;
            end
         end
         if (we && wi < n_items[d]) tbl[d][wi] = wp;
      end
      #1;
      check_all(tag);
   endtask

   initial begin
      model_reset();
      #3;
      check_all("reset");
      @(negedge Clock);
      Resetn = 1'b1;

      step("lk5",     0, 0, 0,   1, 5, 150);
      step("idle1",   0, 0, 0,   0, 0, 0);
      step("wr2",     1, 2, 75,  0, 0, 0);
      step("lk2",     0, 0, 0,   1, 2, 50);
      step("bypass3", 1, 3, 60,  1, 3, 60);
      step("lk7",     0, 0, 0,   1, 7, 10);
      step("wr6",     1, 6, 33,  0, 0, 0);
      step("idle2",   0, 0, 0,   0, 0, 0);
      step("lk6",     0, 0, 0,   1, 6, 200);
      step("lk5b",    0, 0, 0,   1, 5, 255);
      step("b2b0",    0, 0, 0,   1, 0, 100);
      step("b2b1",    0, 0, 0,   1, 1, 99);
      step("b2b2",    0, 0, 0,   1, 2, 0);
      step("hold",    0, 0, 0,   0, 0, 0);
      step("wr_hold", 1, 2, 9,   0, 0, 0);

      // Asynchronous reset between edges, with a write pending across the next edge.
      step("wr4",     1, 4, 200, 0, 0, 0);
      step("lk4",     0, 0, 0,   1, 4, 250);
      wr_en = 1'b1; wr_item = 3'd4; wr_price = 8'd7;
      sel_valid = 1'b1; sel = 3'd4; credit = 8'd150;
      #2;
      Resetn = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(posedge Clock);
      #1;
      check_all("in_rst");
      @(negedge Clock);
      Resetn = 1'b1;
      step("post_rst", 0, 0, 0, 1, 4, 150);
      step("post_rst2", 0, 0, 0, 1, 3, 100);

      for (int k = 0; k < 300; k++) begin
         step("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
      end
      step("final", 0, 0, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/item_price_table.md
ITEM_PRICE_TABLE -- requirements
Module: item_price_table

Interface
REQ-001 The block SHALL have parameter NUM_ITEMS, default 8, meaning the number of selectable items (2..16).
REQ-002 The block SHALL have parameter SEL_W, default 3, meaning the item-select width, with 2**SEL_W >= NUM_ITEMS.
REQ-003 The block SHALL have parameter PRICE_W, default 8, meaning the price and credit width in cents, unsigned.
REQ-004 The block SHALL have parameter DEFAULT_PRICE, default 8'd100, meaning the price loaded into every entry at reset.
REQ-005 Port Clock  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 Port Resetn  input  1  SHALL be the reset: asynchronous, active-low.
REQ-007 Port wr_en  input  1  SHALL request a price-table write.
REQ-008 Port wr_item  input  SEL_W  SHALL give the entry to write.
REQ-009 Port wr_price  input  PRICE_W  SHALL give the new price.
REQ-010 Port sel_valid  input  1  SHALL request a lookup.
REQ-011 Port sel  input  SEL_W  SHALL give the item to look up.
REQ-012 Port credit  input  PRICE_W  SHALL give the inserted credit, sampled with sel_valid.
REQ-013 Port price  output  PRICE_W  SHALL carry the looked-up price, registered.
REQ-014 Port price_valid  output  1  SHALL pulse high for one cycle when price/flags are updated.
REQ-015 Port sel_err  output  1  SHALL flag a lookup with sel >= NUM_ITEMS.
REQ-016 Port enough  output  1  SHALL flag credit >= price.
REQ-017 Port change  output  PRICE_W  SHALL carry credit - price when enough, else 0.
REQ-018 Port wr_err  output  1  SHALL pulse for one cycle on a write with wr_item >= NUM_ITEMS.

Function
REQ-019 The table SHALL hold NUM_ITEMS registers of PRICE_W bits; no latches, no combinational path from sel to price.
REQ-020 Write: wr_en high at edge with wr_item < NUM_ITEMS SHALL update that entry at that edge; out-of-range write SHALL leave table unchanged and pulse wr_err next cycle.
REQ-021 Lookup latency SHALL be exactly 1 cycle: sel_valid at edge N -> price, sel_err, enough, change, price_valid=1 visible after edge N.
REQ-022 price_valid SHALL be low in any cycle not following a sel_valid edge; lookups every cycle SHALL be accepted back-to-back.
REQ-023 price, sel_err, enough, change SHALL hold their last values until the next lookup.
REQ-024 Out-of-range lookup SHALL give price=0, sel_err=1, enough=0, change=0, price_valid=1.
REQ-025 Simultaneous write and lookup to the same in-range item SHALL return the new wr_price (write-first bypass); enough/change SHALL use that value.
REQ-026 enough/change comparison SHALL be unsigned, PRICE_W bits, no wrap: credit == price gives enough=1, change=0.
REQ-027 A write to an entry SHALL NOT alter already-registered outputs.

Reset
REQ-028 Resetn low SHALL immediately, independent of Clock, set every table entry to DEFAULT_PRICE and price=0, price_valid=0, sel_err=0, enough=0, change=0, wr_err=0.
REQ-029 Reset asserted mid-lookup or mid-write SHALL discard that operation; first lookup after release SHALL return DEFAULT_PRICE for any entry not written since.

Verification
REQ-030 Reset, then lookup sel=5, credit=150 -> next cycle price=100, enough=1, change=50, price_valid=1 for one cycle.
REQ-031 Write item 2 = 75, then lookup sel=2, credit=50 -> price=75, enough=0, change=0.
REQ-032 Same-cycle wr_item=3 wr_price=60 and sel=3 credit=60 -> price=60, enough=1, change=0.
REQ-033 NUM_ITEMS=6: lookup sel=7 -> sel_err=1, price=0; write wr_item=6 -> wr_err pulse, table unchanged.
REQ-034 Back-to-back lookups sel=0,1,2 on consecutive cycles -> price_valid high three cycles, prices in order.
REQ-035 Write item 4 = 200, assert Resetn low between edges -> outputs cleared at once; lookup item 4 after release returns 100.
